// File: rtl/bram_stream_reader.sv
// Burst read controller for one BRAM port. Reads `length` consecutive words
// starting at `base_addr` and presents them as a valid/ready stream. The
// one-cycle BRAM read latency is absorbed by a 2-entry output FIFO. A read is
// issued only when the FIFO is guaranteed to have room for its data, so the
// FIFO cannot overflow.
module bram_stream_reader #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [RAM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [RAM_ADDR_WIDTH:0]   length_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ram_wr_o,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [RAM_DATA_WIDTH-1:0] ram_data_in_o,
  input  logic [RAM_DATA_WIDTH-1:0] ram_data_out_i,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic [RAM_DATA_WIDTH-1:0] m_data_o,
  output logic                      m_last_o
);

  localparam int CW = RAM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t                    state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q;
  logic [CW-1:0]             length_q;
  logic [CW-1:0]             issued_q;
  logic [CW-1:0]             accepted_q;
  logic                      inflight_q;
  logic [RAM_DATA_WIDTH-1:0] fifo_q [2];
  logic                      wr_ptr_q, rd_ptr_q;
  logic [1:0]                count_q, count_d;

  logic                      issue;
  logic                      push, pop;
  logic [1:0]                occ_after_pop;

  // Stream side is driven purely from registers: never from m_ready_i.
  assign m_valid_o     = (count_q != 2'd0);
  assign m_data_o      = fifo_q[rd_ptr_q];
  assign m_last_o      = m_valid_o && (accepted_q == (length_q - CW'(1)));
  assign ram_addr_o    = ram_addr_q;
  assign ram_wr_o      = 1'b0;
  assign ram_data_in_o = '0;

  // Data returning from the BRAM is always pushed; the credit rule reserved room for it.
  assign push          = inflight_q;
  assign pop           = m_valid_o && m_ready_i;
  assign occ_after_pop = count_q - {1'b0, pop};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: a burst ends on the handshake of its last word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = (length_i == '0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (pop && m_last_o) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs, including the credit-checked read issue decision.
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    issue  = 1'b0;
    case (state_q)
      S_RUN: begin
        busy_o = 1'b1;
        issue  = (issued_q < length_q) &&
                 (({1'b0, occ_after_pop} + {2'b00, inflight_q}) < 3'd2);
      end
      S_FINISH: done_o = 1'b1;
      default: ;
    endcase
  end

  // FIFO occupancy after this cycle's push and pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Burst capture, address/counter advance, and the 2-entry output FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ram_addr_q <= '0;
      length_q   <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        length_q   <= length_i;
        issued_q   <= '0;
        accepted_q <= '0;
        // A zero-length burst touches nothing on the BRAM port.
        if (length_i != '0) ram_addr_q <= base_addr_i;
      end
      if (issue) begin
        ram_addr_q <= ram_addr_q + 1'b1;
        issued_q   <= issued_q + CW'(1);
      end
      inflight_q <= issue;
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_data_out_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        accepted_q <= accepted_q + CW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed testbench for bram_stream_reader with a synchronous-read BRAM model.
module tb_bram_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy, done, ram_wr;
  logic [3:0] ram_addr;
  logic [7:0] ram_data_in, ram_data_out;
  logic       m_valid, m_ready, m_last;
  logic [7:0] m_data;

  logic [7:0] mem [16];

  int checks = 0;
  int errors = 0;

  // Results gathered by the stream collector
  logic [7:0] got_data[$];
  bit         got_last[$];
  int         got_k[$];
  int done_cnt, done_k, stall_viol, ovf, wr_viol, valid_seen, busy_gap;

  bram_stream_reader #(.RAM_DATA_WIDTH(8), .RAM_ADDR_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .base_addr_i(base_addr),
    .length_i(length), .busy_o(busy), .done_o(done), .ram_wr_o(ram_wr),
    .ram_addr_o(ram_addr), .ram_data_in_o(ram_data_in),
    .ram_data_out_i(ram_data_out), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_last_o(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM read port: data valid one cycle after the address is sampled
  always @(posedge clk) ram_data_out <= mem[ram_addr];

  task automatic do_start(input logic [3:0] b, input logic [4:0] l);
    @(negedge clk);
    start = 1'b1; base_addr = b; length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes the stream from the cycle after start acceptance (k=1) until a few
  // cycles past done or until max_k. Records words, stalls and done pulses.
  task automatic collect(input int max_k, input bit bp, input int inj_k);
    bit pat[7];
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    int k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    got_data.delete(); got_last.delete(); got_k.delete();
    done_cnt = 0; done_k = -1; stall_viol = 0; ovf = 0; wr_viol = 0;
    valid_seen = 0; busy_gap = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    k = 1;
    while (k <= max_k) begin
      m_ready = bp ? pat[(k - 1) % 7] : 1'b1;
      if (k == inj_k) begin
        start = 1'b1; base_addr = 4'd8; length = 5'd5;
      end else begin
        start = 1'b0;
      end
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        stall_viol++;
      if (m_valid) valid_seen++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end else if (done_k < 0 && !busy) begin
        busy_gap++;
      end
      if (dut.count_q > 2'd2) ovf++;
      if (ram_wr !== 1'b0 || ram_data_in !== 8'h00) wr_viol++;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        got_last.push_back(m_last);
        got_k.push_back(k);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done_k >= 0 && k >= done_k + 4) break;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done_k < 0) begin
      checks++; errors++;
      $display("FAIL timeout: no done within %0d cycles", max_k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b last=%b, expected all 0",
               busy, done, m_valid, m_last);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (m_data !== 8'h00 || ram_addr !== 4'h0) begin
      errors++;
      $display("FAIL reset_data: m_data=%h ram_addr=%h, expected 00/0", m_data, ram_addr);
    end
    checks++;
    if (ram_wr !== 1'b0 || ram_data_in !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr: ram_wr=%b ram_data_in=%h, expected 0/00", ram_wr, ram_data_in);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    do_start(4'd2, 5'd4);
    checks++;
    if (busy !== 1'b1 || ram_addr !== 4'd2 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_first: busy=%b ram_addr=%0d valid=%b, expected 1/2/0",
               busy, ram_addr, m_valid);
    end
    collect(40, 1'b0, 0);
    checks++;
    if (got_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d words, expected 4", got_data.size());
    end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h12 + 8'(i) || got_k[i] != 3 + i || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_word%0d: data=%h cyc=%0d last=%b, expected %h/%0d/%b",
                 i, got_data[i], got_k[i], got_last[i], 8'h12 + 8'(i), 3 + i, i == 3);
      end
    end
    checks++;
    if (done_k != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: done at cycle %0d count %0d, expected 7/1", done_k, done_cnt);
    end
    checks++;
    if (busy_gap != 0 || wr_viol != 0) begin
      errors++;
      $display("FAIL basic_busy: busy gaps=%0d wr violations=%0d, expected 0/0", busy_gap, wr_viol);
    end
    $display("test_basic: %0d words, done at cycle %0d", got_data.size(), done_k);
  endtask

  task automatic test_wrap_full();
    do_start(4'd14, 5'd16);
    collect(80, 1'b0, 0);
    checks++;
    if (got_data.size() != 16) begin
      errors++;
      $display("FAIL wrap_count: got %0d words, expected 16", got_data.size());
    end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      logic [3:0] a;
      a = 4'(14 + i);
      checks++;
      if (got_data[i] !== 8'h10 + 8'(a) || got_k[i] != 3 + i || got_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL wrap_word%0d: data=%h cyc=%0d last=%b, expected %h/%0d/%b",
                 i, got_data[i], got_k[i], got_last[i], 8'h10 + 8'(a), 3 + i, i == 15);
      end
    end
    checks++;
    if (ram_addr !== 4'd14 || done_cnt != 1) begin
      errors++;
      $display("FAIL wrap_end: ram_addr=%0d done_count=%0d, expected 14/1", ram_addr, done_cnt);
    end
    $display("test_wrap_full: %0d words", got_data.size());
  endtask

  task automatic test_backpressure();
    do_start(4'd5, 5'd5);
    collect(80, 1'b1, 0);
    checks++;
    if (got_data.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d words, expected 5", got_data.size());
    end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h15 + 8'(i) || got_last[i] !== (i == 4)) begin
        errors++;
        $display("FAIL bp_word%0d: data=%h last=%b, expected %h/%b",
                 i, got_data[i], got_last[i], 8'h15 + 8'(i), i == 4);
      end
    end
    checks++;
    if (stall_viol != 0 || ovf != 0) begin
      errors++;
      $display("FAIL bp_stall: unstable stalls=%0d overflows=%0d, expected 0/0", stall_viol, ovf);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: done count %0d, expected 1", done_cnt);
    end
    $display("test_backpressure: %0d words", got_data.size());
  endtask

  task automatic test_zero_length();
    logic [3:0] addr_before;
    addr_before = ram_addr;
    do_start(4'd9, 5'd0);
    collect(20, 1'b0, 0);
    checks++;
    if (done_k != 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_done: done at cycle %0d count %0d, expected 1/1", done_k, done_cnt);
    end
    checks++;
    if (valid_seen != 0 || ram_addr !== addr_before) begin
      errors++;
      $display("FAIL zero_quiet: valid cycles=%0d ram_addr=%0d, expected 0/%0d",
               valid_seen, ram_addr, addr_before);
    end
    $display("test_zero_length: done at cycle %0d", done_k);
  endtask

  task automatic test_start_while_busy();
    do_start(4'd0, 5'd3);
    collect(40, 1'b0, 2);
    checks++;
    if (got_data.size() != 3 || done_cnt != 1) begin
      errors++;
      $display("FAIL busy_start_count: words=%0d done count=%0d, expected 3/1",
               got_data.size(), done_cnt);
    end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL busy_start_word%0d: data=%h, expected %h", i, got_data[i], 8'h10 + 8'(i));
      end
    end
    checks++;
    if (ram_addr !== 4'd3) begin
      errors++;
      $display("FAIL busy_start_addr: ram_addr=%0d, expected 3", ram_addr);
    end
    $display("test_start_while_busy: %0d words", got_data.size());
  endtask

  task automatic test_reset_mid_burst();
    int bad_done, bad_valid;
    do_start(4'd3, 5'd6);
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    // two words (13, 14) have transferred; third word is on the bus
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'h15 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b data=%h busy=%b, expected 1/15/1", m_valid, m_data, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        m_data !== 8'h00 || ram_addr !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b done=%b valid=%b last=%b data=%h addr=%h, expected 0s",
               busy, done, m_valid, m_last, m_data, ram_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_done = 0; bad_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) bad_done++;
      if (m_valid) bad_valid++;
    end
    checks++;
    if (bad_done != 0 || bad_valid != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: done cycles=%0d valid cycles=%0d, expected 0/0", bad_done, bad_valid);
    end
    do_start(4'd0, 5'd2);
    collect(30, 1'b0, 0);
    checks++;
    if (got_data.size() != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_count: words=%0d done count=%0d, expected 2/1", got_data.size(), done_cnt);
    end
    for (int i = 0; i < 2 && i < got_data.size(); i++) begin
      checks++;
      if (got_data[i] !== 8'h10 + 8'(i) || got_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL rstmid_word%0d: data=%h last=%b, expected %h/%b",
                 i, got_data[i], got_last[i], 8'h10 + 8'(i), i == 1);
      end
    end
    $display("test_reset_mid_burst: %0d words after reset", got_data.size());
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    test_reset();
    test_basic();
    test_wrap_full();
    test_backpressure();
    test_zero_length();
    test_start_while_busy();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for one port of the team's dual-port BRAM. Reads a burst of `length` consecutive words from `base_addr` and presents them as a valid/ready stream, for example weight or activation fetch into a NN datapath.
- Absorbs the 1-cycle BRAM read latency with a 2-entry output buffer. Sustains 1 word/cycle under no backpressure and never drops or duplicates a word under backpressure.

Parameters:
RAM_DATA_WIDTH, 8, word width; must match the attached BRAM
RAM_ADDR_WIDTH, 4, BRAM address bits; depth = 2**RAM_ADDR_WIDTH

Ports:
clk  input  1  single clock for all logic and the BRAM port
rst  input  1  asynchronous, active-low reset
start  input  1  1-cycle request to begin a burst; sampled only in IDLE
base_addr  input  RAM_ADDR_WIDTH  first word address; captured when start is accepted
length  input  RAM_ADDR_WIDTH+1  words to read, 0..2**RAM_ADDR_WIDTH; captured with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  1-cycle pulse when the burst completes
ram_wr  output  1  BRAM write strobe; constant 0
ram_addr  output  RAM_ADDR_WIDTH  BRAM address, registered
ram_data_in  output  RAM_DATA_WIDTH  BRAM write data; constant 0
ram_data_out  input  RAM_DATA_WIDTH  BRAM read data; valid 1 cycle after ram_addr is sampled
m_valid  output  1  stream word valid
m_ready  input  1  downstream accepts word
m_data  output  RAM_DATA_WIDTH  stream word
m_last  output  1  high with the final word of the burst

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_addr=0.
  - Buffer, issue counter, accept counter and in-flight flag are all cleared.
  - Reset mid-burst abandons the burst. No done pulse. Stale BRAM data returning after reset is discarded.
- States:
  - IDLE: start=1 captures base_addr and length.
    - length=0: go to FINISH.
    - Otherwise: go to RUN.
  - RUN: issue reads and stream words. When the handshake of the word with m_last=1 occurs, go to FINISH.
  - FINISH: done=1 and busy=0 for exactly this cycle, then go to IDLE.
- start while busy, or during the FINISH cycle, is ignored.
- Read issue:
  - In RUN, a read is issued in a cycle when both hold:
    - issued < length
    - (buffer occupancy after this cycle's pop) + in_flight < 2
  - Issuing a read drives ram_addr to the next address from the following edge. The in-flight flag is set for one cycle. The returning ram_data_out is written into the buffer on the next edge.
- Latency:
  - start accepted at edge E0.
  - ram_addr = base_addr during the cycle after E0.
  - m_valid = 1 two cycles after E0.
- Address arithmetic: ram_addr increments by 1 per issued read, modulo 2**RAM_ADDR_WIDTH. base_addr = 2**RAM_ADDR_WIDTH - 1 wraps to 0.
- Counters:
  - Issue and accept counters are RAM_ADDR_WIDTH+1 bits.
  - length = 2**RAM_ADDR_WIDTH reads every word exactly once.
- Stream handshake:
  - A word transfers on any edge with m_valid & m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last are held stable and m_valid stays 1.
  - m_valid never depends combinationally on m_ready.
- Buffer:
  - 2-entry FIFO; push and pop in the same cycle are allowed.
  - The credit rule guarantees no overflow. An overflow is an assertion failure in the bench.
- m_last: high only on the word whose accept index equals length-1.
- Throughput: with m_ready=1 continuously, words stream on consecutive cycles with no bubbles.
- ram_wr and ram_data_in are 0 at all times. This block is read-only on its port.

Test Plan:
- Basic burst:
  - Stimulus: mem[i]=i+0x10; start with base=2, length=4; m_ready=1.
  - Required: m_data 0x12, 0x13, 0x14, 0x15 on 4 consecutive cycles, starting 2 cycles after start. m_last on 0x15. done 1 cycle after the last handshake. busy high throughout the burst.
- Wrap and full depth:
  - Stimulus: base=14, length=16.
  - Required: 16 words in address order 14, 15, 0, 1, …, 13. Each word appears exactly once. m_last only on the 16th word.
- Backpressure:
  - Stimulus: length=5; m_ready toggles 1,0,0,1,0,1,1,…
  - Required: the same 5 words in order. m_data is stable during every stall. No word is lost or duplicated. Buffer occupancy never exceeds 2. No read is issued while the credit rule is full.
- Zero length:
  - Stimulus: start with length=0.
  - Required: m_valid never asserts. No read is issued; ram_addr is unchanged. done pulses the cycle after start.
- Start while busy:
  - Stimulus: start again in the middle of a length=3 burst.
  - Required: the second start is ignored. Exactly 3 words and 1 done pulse.
- Reset mid-burst:
  - Stimulus: assert rst with 2 of 6 words transferred.
  - Required: all outputs reach their reset values without waiting for a clk edge. No done pulse. A new burst after reset release (base=0, length=2) streams mem[0], mem[1] correctly.
